// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the parity frame scheduler.
// Holds the FSM state encoding, frame width, mode codes and reference parity.
package parity_sched_pkg;

    localparam int FRAME_BITS = 8;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        SAMPLE,
        RESP
    } state_t;

    // Verdict a correct checker must give for this byte and mode.
    function automatic logic ref_ok(
        input logic [FRAME_BITS-1:0] d,
        input logic                  mode
    );
        return (mode == MODE_ODD) ? (^d) : ~(^d);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps.
// Ports: req (requests), ptr (first index searched), gnt (one-hot),
// gnt_id (encoded winner), any (some request present).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                gnt_id  = jj;
            end
        end
    end

endmodule

// File: rtl/parity_frame_sched.sv
// Round-robin scheduler sharing one serial parity checker among requesters.
// Ports: req_* byte offers/grant, ser_* checker side, rsp_* verdict
// response, chk_err sticky checker-disagreement flag; reset is async low.
module parity_frame_sched
    import parity_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_mode,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       ser_clear,
    output logic                       ser_valid,
    output logic                       ser_data,
    output logic                       ser_mode,
    input  logic                       ser_parity_ok,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_ok,
    output logic                       chk_err
);

    localparam int IW = $clog2(NUM_REQ);

    state_t                state;
    state_t                state_n;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         gnt_id;
    logic [NUM_REQ-1:0]    gnt;
    logic                  any;
    logic                  xfer;
    logic [2:0]            cnt;
    logic [FRAME_BITS-1:0] data_q;
    logic [FRAME_BITS-1:0] shreg;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Grant is gated by reset so req_ready is low while reset is held.
    always_comb begin
        state_n   = state;
        req_ready = '0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset && any) begin
                    req_ready = gnt;
                    xfer      = 1'b1;
                    state_n   = CLEAR;
                end
            end
            CLEAR:  state_n = SHIFT;
            SHIFT: begin
                if (cnt == 3'd7) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: state_n = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            cnt       <= '0;
            data_q    <= '0;
            shreg     <= '0;
            ser_clear <= 1'b0;
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
            ser_mode  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_ok    <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            ser_clear <= (state_n == CLEAR);
            ser_valid <= (state_n == SHIFT);
            rsp_valid <= (state_n == RESP);
            ser_data  <= 1'b0;
            if (xfer) begin
                data_q   <= req_data[int'(gnt_id)*FRAME_BITS +: FRAME_BITS];
                shreg    <= req_data[int'(gnt_id)*FRAME_BITS +: FRAME_BITS];
                ser_mode <= req_mode[gnt_id];
                rsp_id   <= gnt_id;
                cnt      <= '0;
                if (int'(gnt_id) == NUM_REQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_id + 1'b1;
                end
            end
            if (state_n == SHIFT) begin
                ser_data <= shreg[FRAME_BITS-1];
                shreg    <= shreg << 1;
            end
            if (state == SHIFT) begin
                cnt <= cnt + 1'b1;
            end
            if (state == SAMPLE) begin
                rsp_ok <= ser_parity_ok;
                if (ser_parity_ok != ref_ok(data_q, ser_mode)) begin
                    chk_err <= 1'b1;
                end
            end
            if (state_n == RESP || state_n == IDLE) begin
                ser_mode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_sched.sv
// Self-checking bench for parity_frame_sched with a serial checker model.
// Table-driven frames plus round-robin, backpressure, fault and reset cases.
module tb_parity_frame_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_mode = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     rd [N];
    logic [N*8-1:0] req_data;
    logic           ser_clear;
    logic           ser_valid;
    logic           ser_data;
    logic           ser_mode;
    logic           ser_parity_ok;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic           rsp_ok;
    logic           chk_err;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    parity_frame_sched #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_mode      (req_mode),
        .req_ready     (req_ready),
        .ser_clear     (ser_clear),
        .ser_valid     (ser_valid),
        .ser_data      (ser_data),
        .ser_mode      (ser_mode),
        .ser_parity_ok (ser_parity_ok),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_ok        (rsp_ok),
        .chk_err       (chk_err)
    );

    // Serial checker model; fault inverts its verdict.
    logic acc = 1'b0;
    logic fault = 1'b0;
    always @(posedge clk) begin
        if (ser_clear) acc <= 1'b0;
        else if (ser_valid) acc <= acc ^ ser_data;
    end
    assign ser_parity_ok = (ser_mode ? acc : ~acc) ^ fault;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    function automatic logic model_ok(input logic [7:0] d,
                                      input logic m);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        return m ? (ones % 2 == 1) : (ones % 2 == 0);
    endfunction

    typedef struct {
        int   id;
        logic ok;
    } rsp_t;

    rsp_t       sbq[$];
    rsp_t       e;
    int         glog[$];
    int         xlog[$];
    int         xfer_cnt = 0;
    int         xfer_cyc = 0;
    int         hs_cyc = 0;
    int         rsp_cnt = 0;
    logic [7:0] bits = '0;

    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
        end else begin
            if (ser_clear) bits = '0;
            else if (ser_valid) bits = {bits[6:0], ser_data};
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sbq.push_back('{id: i,
                        ok: model_ok(rd[i], req_mode[i]) ^ fault});
                    glog.push_back(i);
                    xlog.push_back(cyc);
                    xfer_cyc = cyc;
                    xfer_cnt++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                hs_cyc = cyc;
                rsp_cnt++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: id %0d with empty queue",
                             rsp_id);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_ok", 32'(rsp_ok), 32'(e.ok));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int n0, input string nm);
        int t;
        t = 0;
        while (xfer_cnt == n0 && t < 60) begin
            tick();
            t++;
        end
        if (xfer_cnt == n0) chk({nm, "_xfer_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_rsp(input string nm);
        int t;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        if (rsp_valid !== 1'b1) chk({nm, "_rsp_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk(nm, 32'({req_ready, ser_clear, ser_valid, ser_data, ser_mode,
                     rsp_valid, rsp_id, rsp_ok, chk_err}), 32'(0));
    endtask

    // Waits for a transfer from id, then its response; checks it.
    task automatic await_frame(input int id, input logic [7:0] d,
                               input logic eok, input logic eerr,
                               input int n0, input string nm);
        int xc;
        wait_xfer(n0, nm);
        req_valid[id] = 1'b0;
        chk({nm, "_gnt"}, 32'(glog[$]), 32'(id));
        xc = xfer_cyc;
        wait_rsp(nm);
        chk({nm, "_lat"}, 32'(cyc - xc), 32'(11));
        chk({nm, "_id"}, 32'(rsp_id), 32'(id));
        chk({nm, "_ok"}, 32'(rsp_ok), 32'(eok));
        chk({nm, "_err"}, 32'(chk_err), 32'(eerr));
        chk({nm, "_bits"}, 32'(bits), 32'(d));
    endtask

    task automatic send_frame(input int id, input logic [7:0] d,
                              input logic m, input logic eok,
                              input logic eerr, input string nm);
        int n0;
        rd[id] = d;
        req_mode[id] = m;
        n0 = xfer_cnt;
        req_valid[id] = 1'b1;
        await_frame(id, d, eok, eerr, n0, nm);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       m;
        logic       eok;
    } vec_t;

    vec_t vt[7];

    initial begin
        #400000;
        $display("FAIL watchdog: time %0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int r0;
        int xc;
        int t;
        for (int i = 0; i < N; i++) rd[i] = 8'h00;

        vt[0] = '{0, 8'hA5, 1'b0, 1'b1};
        vt[1] = '{2, 8'h07, 1'b0, 1'b0};
        vt[2] = '{2, 8'h07, 1'b1, 1'b1};
        vt[3] = '{1, 8'h00, 1'b0, 1'b1};
        vt[4] = '{3, 8'h80, 1'b1, 1'b1};
        vt[5] = '{1, 8'hFE, 1'b1, 1'b1};
        vt[6] = '{3, 8'h3C, 1'b1, 1'b0};

        req_valid = 4'b0001;
        tick();
        tick();
        chk_reset_outs("reset_outs");
        req_valid = '0;
        reset = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            send_frame(vt[v].id, vt[v].d, vt[v].m, vt[v].eok, 1'b0,
                       $sformatf("vec%0d", v));
        end
        tick();

        // All requesters pending: rotation and 12-cycle period.
        do_reset();
        glog.delete();
        xlog.delete();
        for (int i = 0; i < N; i++) rd[i] = 8'(8'h11 * (i + 1));
        req_mode = 4'b1010;
        n0 = xfer_cnt;
        req_valid = 4'hF;
        t = 0;
        while (xfer_cnt < n0 + 6 && t < 120) begin
            tick();
            t++;
        end
        req_valid = '0;
        chk("rr_count", 32'(xfer_cnt - n0), 32'(6));
        for (int k = 0; k < 6 && k < glog.size(); k++) begin
            chk($sformatf("rr_order%0d", k), 32'(glog[k]), 32'(k % 4));
            if (k > 0)
                chk($sformatf("rr_gap%0d", k),
                    32'(xlog[k] - xlog[k-1]), 32'(12));
        end
        wait_rsp("rr_tail");
        tick();

        // Response held off while requester 1 waits.
        rsp_ready = 1'b0;
        send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0, "bp");
        rd[1] = 8'h81;
        req_mode[1] = 1'b0;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k),
                32'({rsp_valid, rsp_id, rsp_ok, req_ready}),
                32'({1'b1, 2'd0, 1'b0, 4'b0000}));
        end
        n0 = xfer_cnt;
        rsp_ready = 1'b1;
        wait_xfer(n0, "bp_next");
        req_valid[1] = 1'b0;
        chk("bp_next_gnt", 32'(glog[$]), 32'(1));
        chk("bp_next_cyc", 32'(xfer_cyc - hs_cyc), 32'(1));
        wait_rsp("bp_next");
        chk("bp_next_ok", 32'(rsp_ok), 32'(1));
        tick();

        // Faulty checker for one frame, then a correct one.
        fault = 1'b1;
        send_frame(3, 8'hFF, 1'b0, 1'b0, 1'b1, "fault");
        fault = 1'b0;
        send_frame(2, 8'h07, 1'b1, 1'b1, 1'b1, "post_fault");
        tick();
        chk("err_sticky", 32'(chk_err), 32'(1));

        // Reset during SHIFT bit 4 discards the frame.
        rd[2] = 8'h33;
        req_mode[2] = 1'b0;
        n0 = xfer_cnt;
        req_valid[2] = 1'b1;
        wait_xfer(n0, "rst_pre");
        req_valid[2] = 1'b0;
        xc = xfer_cyc;
        t = 0;
        while (cyc < xc + 6 && t < 20) begin
            tick();
            t++;
        end
        chk("rst_in_shift", 32'(ser_valid), 32'(1));
        rd[0] = 8'hC3;
        req_mode[0] = 1'b0;
        req_valid[0] = 1'b1;
        r0 = rsp_cnt;
        reset = 1'b0;
        #1;
        chk_reset_outs("rst_async");
        tick();
        tick();
        n0 = xfer_cnt;
        reset = 1'b1;
        await_frame(0, 8'hC3, 1'b1, 1'b0, n0, "rst_after");
        chk("rst_no_rsp", 32'(rsp_cnt), 32'(r0));
        tick();
        tick();
        chk("sb_drain", 32'(sbq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
